// File: rtl/elastic_pipe_reg.sv
// Inter-stage pipeline register: 2-entry main/skid buffer with valid/ready
// on both sides, registered in_ready, synchronous flush to bubbles.
module elastic_pipe_reg #(
  parameter int                 WIDTH      = 32,
  parameter bit                 CLEAR_DATA = 1'b1,
  parameter logic [WIDTH-1:0]   BUBBLE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] main_vacated;
  logic [WIDTH-1:0] skid_vacated;

  // Handshake outputs come straight from state flops only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign main_vacated = CLEAR_DATA ? BUBBLE : main_q;
  assign skid_vacated = CLEAR_DATA ? BUBBLE : skid_q;

  always_comb begin
    out_data = main_q;
    if (CLEAR_DATA && !out_valid) begin
      out_data = BUBBLE;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = HALF;
            main_d  = in_data;
          end
        end
        HALF: begin
          unique case (1'b1)
            in_fire & out_fire: begin
              main_d = in_data;
            end
            out_fire & ~in_fire: begin
              state_d = EMPTY;
              main_d  = main_vacated;
            end
            in_fire & ~out_fire: begin
              state_d = FULL;
              skid_d  = in_data;
            end
            default: begin
              state_d = HALF;
            end
          endcase
        end
        FULL: begin
          if (out_fire) begin
            state_d = HALF;
            main_d  = skid_q;
            skid_d  = skid_vacated;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios plus random valid/ready
// traffic, checked by a negedge monitor against a reference entry queue.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int nvec  = 0;
  int nfail = 0;
  int accepted = 0;
  bit armed = 1'b0;
  logic [31:0] sb[$];

  elastic_pipe_reg #(
    .WIDTH(32),
    .CLEAR_DATA(1'b1),
    .BUBBLE(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: entries accepted and not yet delivered, oldest first.
  always @(negedge clk) begin
    bit of, inf;
    logic [31:0] exp_d;
    if (armed) begin
      exp_d = (sb.size() > 0) ? sb[0] : 32'h0;
      chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() > 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, sb.size() < 2});
      chk("occupancy", {30'b0, occupancy}, sb.size());
      chk("out_data", out_data, exp_d);
    end
    of  = (sb.size() > 0) && out_ready;
    inf = in_valid && (sb.size() < 2);
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (of) void'(sb.pop_front());
      if (inf) begin
        sb.push_back(in_data);
        accepted++;
      end
    end
    if (reset) armed = 1'b1;
  end

  initial begin
    int cyc;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;

    // 1: reset with a live offer
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", {31'b0, out_valid}, 32'h0);
    chk("t1_data", out_data, 32'h0);
    chk("t1_occ", {30'b0, occupancy}, 32'h0);
    chk("t1_ready", {31'b0, in_ready}, 32'h1);

    // 2: back-to-back stream
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    tick();
    in_data = 32'h2;
    @(negedge clk);
    chk("t2_d1", out_data, 32'h1);
    tick();
    in_data = 32'h3;
    @(negedge clk);
    chk("t2_d2", out_data, 32'h2);
    chk("t2_rdy", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_d3", out_data, 32'h3);
    tick();

    // 3: backpressure fills both slots
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    @(negedge clk);
    chk("t3_occ1", {30'b0, occupancy}, 32'h1);
    tick();
    in_data = 32'hC;
    @(negedge clk);
    chk("t3_occ2", {30'b0, occupancy}, 32'h2);
    chk("t3_rdy0", {31'b0, in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("t3_hold", out_data, 32'hA);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_b", out_data, 32'hB);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_c", out_data, 32'hC);
    tick();
    @(negedge clk);
    chk("t3_empty", {30'b0, occupancy}, 32'h0);

    // 4: flush while full, with an offer
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_data = 32'hC;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", {31'b0, out_valid}, 32'h0);
    chk("t4_data", out_data, 32'h0);
    chk("t4_occ", {30'b0, occupancy}, 32'h0);
    chk("t4_rdy", {31'b0, in_ready}, 32'h1);
    tick();
    out_ready = 1'b1;
    tick();
    tick();

    // 5: simultaneous fire in HALF
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    out_ready = 1'b1;
    in_data   = 32'h6;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_occ", {30'b0, occupancy}, 32'h1);
    chk("t5_data", out_data, 32'h6);
    tick();
    tick();

    // 6: random traffic with occasional flush/reset
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 499) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      tick();
      cyc++;
    end
    nvec++;
    if (accepted < 10000) begin
      nfail++;
      $display("FAIL t6_budget: accepted %0d expected 10000", accepted);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t6_drain", {30'b0, occupancy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
